student_motion: RTL and testbench



---
 rtl/game_pkg.sv | 31 +++
 rtl/student_motion.sv | 129 ++++++++++++
 tb/tb_student_motion.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared screen geometry, coordinate widths and motion FSM encoding for the
// sprite movers of the game.
package game_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int SPRITE_W = 32;
    localparam int SPRITE_H = 32;

    localparam int X_W = 11;
    localparam int Y_W = 10;
    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        COMMIT
    } motion_state_t;

    // Saturate a signed screen coordinate into [lo, hi].
    function automatic logic signed [COORD_W-1:0] clamp(
        input logic signed [COORD_W-1:0] v,
        input logic signed [COORD_W-1:0] lo,
        input logic signed [COORD_W-1:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/student_motion.sv
// Student sprite position, facing and walk animation, updated once per frame
// through an IDLE -> CALC -> COMMIT sequence started by the vblank tick.
module student_motion
    import game_pkg::*;
#(
    parameter int STEP     = 2,
    parameter int START_X  = 304,
    parameter int START_Y  = 400,
    parameter int ANIM_DIV = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_tick,
    input  logic           enable,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_up,
    input  logic           btn_down,
    output logic [X_W-1:0] student_x,
    output logic [Y_W-1:0] student_y,
    output logic           facing,
    output logic           moving,
    output logic [1:0]     anim_frame,
    output logic           update_done
);

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);
    localparam logic signed [COORD_W-1:0] STEP_S = COORD_W'(STEP);
    localparam logic signed [COORD_W-1:0] ZERO_S = '0;
    localparam logic signed [COORD_W-1:0] X_MAX  = COORD_W'(H_ACTIVE - SPRITE_W);
    localparam logic signed [COORD_W-1:0] Y_MAX  = COORD_W'(V_ACTIVE - SPRITE_H);

    motion_state_t state, state_nx;

    logic                      left_q, right_q, up_q, down_q;
    logic signed [COORD_W-1:0] dx, dy, x_sum, y_sum;
    logic [X_W-1:0]            nx_q;
    logic [Y_W-1:0]            ny_q;
    logic [CNT_W-1:0]          cnt_q;

    // NOTE: every signal written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (frame_tick && enable) state_nx = CALC;
            CALC:    state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Opposing buttons on one axis cancel out.
    always_comb begin
        dx = '0;
        dy = '0;
        if (right_q && !left_q)      dx = STEP_S;
        else if (left_q && !right_q) dx = -STEP_S;
        if (down_q && !up_q)         dy = STEP_S;
        else if (up_q && !down_q)    dy = -STEP_S;
        x_sum = $signed({1'b0, student_x}) + dx;
        y_sum = $signed({2'b0, student_y}) + dy;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            nx_q        <= X_W'(START_X);
            ny_q        <= Y_W'(START_Y);
            student_x   <= X_W'(START_X);
            student_y   <= Y_W'(START_Y);
            facing      <= 1'b0;
            moving      <= 1'b0;
            anim_frame  <= 2'd0;
            cnt_q       <= '0;
            update_done <= 1'b0;
        end else begin
            state       <= state_nx;
            update_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_tick && enable) begin
                        left_q  <= btn_left;
                        right_q <= btn_right;
                        up_q    <= btn_up;
                        down_q  <= btn_down;
                    end else if (!enable) begin
                        moving     <= 1'b0;
                        anim_frame <= 2'd0;
                        cnt_q      <= '0;
                    end
                end
                CALC: begin
                    nx_q <= X_W'(clamp(x_sum, ZERO_S, X_MAX));
                    ny_q <= Y_W'(clamp(y_sum, ZERO_S, Y_MAX));
                end
                COMMIT: begin
                    student_x   <= nx_q;
                    student_y   <= ny_q;
                    update_done <= 1'b1;
                    if (dx < 0)      facing <= 1'b1;
                    else if (dx > 0) facing <= 1'b0;
                    if ((nx_q != student_x) || (ny_q != student_y)) begin
                        moving <= 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q      <= '0;
                            anim_frame <= anim_frame + 2'd1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        moving     <= 1'b0;
                        cnt_q      <= '0;
                        anim_frame <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_student_motion.sv
// Self-checking bench for student_motion: vector table, hand-written corner
// sequences and randomized frames against a frame-level reference model.
module tb_student_motion;

    localparam int STEP  = 2;
    localparam int X_MAX = 640 - 32;
    localparam int Y_MAX = 480 - 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0;
    logic enable = 1'b1;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;

    logic [10:0] student_x;
    logic [9:0]  student_y;
    logic        facing, moving, update_done;
    logic [1:0]  anim_frame;

    logic [10:0] d1_x;
    logic [9:0]  d1_y;
    logic        d1_facing, d1_moving, d1_done;
    logic [1:0]  d1_anim;

    always #5 clk = ~clk;

    student_motion dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .student_x(student_x), .student_y(student_y), .facing(facing), .moving(moving),
        .anim_frame(anim_frame), .update_done(update_done)
    );

    // Second instance starting one pixel from the left edge.
    student_motion #(.START_X(1), .START_Y(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .student_x(d1_x), .student_y(d1_y), .facing(d1_facing), .moving(d1_moving),
        .anim_frame(d1_anim), .update_done(d1_done)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: sprite state after each committed frame.
    int mx, my, mfacing, mmoving, manim, mmoves;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        mx = 304; my = 400; mfacing = 0; mmoving = 0; manim = 0; mmoves = 0;
    endtask

    task automatic model_step(input logic l, input logic r, input logic u, input logic d);
        int dx, dy, nx, ny;
        dx = (r && !l) ? STEP : ((l && !r) ? -STEP : 0);
        dy = (d && !u) ? STEP : ((u && !d) ? -STEP : 0);
        nx = mx + dx;
        ny = my + dy;
        nx = (nx < 0) ? 0 : ((nx > X_MAX) ? X_MAX : nx);
        ny = (ny < 0) ? 0 : ((ny > Y_MAX) ? Y_MAX : ny);
        mmoving = (nx != mx || ny != my) ? 1 : 0;
        if (dx < 0) mfacing = 1;
        else if (dx > 0) mfacing = 0;
        // Animation frame = number of consecutive moving commits / ANIM_DIV, mod 4.
        mmoves  = mmoving ? mmoves + 1 : 0;
        manim   = (mmoves / 8) % 4;
        mx = nx;
        my = ny;
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_x"}, student_x, mx);
        check({tag, "_y"}, student_y, my);
        check({tag, "_facing"}, facing, mfacing);
        check({tag, "_moving"}, moving, mmoving);
        check({tag, "_anim"}, anim_frame, manim);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        frame_tick = 1'b0;
        enable = 1'b1;
        {btn_left, btn_right, btn_up, btn_down} = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", student_x, 304);
        check("rst_y", student_y, 400);
        check("rst_flags", {facing, moving, anim_frame, update_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One frame tick with the given buttons; checks commit latency and result.
    task automatic frame(input logic l, input logic r, input logic u, input logic d);
        int px;
        px = mx;
        @(negedge clk);
        {btn_left, btn_right, btn_up, btn_down} = {l, r, u, d};
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(posedge clk); #1;
        check("done_early", update_done, 0);
        check("x_early", student_x, px);
        model_step(l, r, u, d);
        @(posedge clk); #1;
        check("done_pulse", update_done, 1);
        compare_model("frame");
        @(posedge clk); #1;
        check("done_single", update_done, 0);
    endtask

    typedef struct {
        logic l, r, u, d;
        int   ex, ey;
        logic ef, em;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int guard, pulses, hold_x;

        tbl[0] = '{l: 0, r: 0, u: 0, d: 0, ex: 304, ey: 400, ef: 0, em: 0};
        tbl[1] = '{l: 0, r: 1, u: 0, d: 0, ex: 306, ey: 400, ef: 0, em: 1};
        tbl[2] = '{l: 1, r: 0, u: 0, d: 0, ex: 304, ey: 400, ef: 1, em: 1};
        tbl[3] = '{l: 0, r: 0, u: 1, d: 1, ex: 304, ey: 400, ef: 1, em: 0};
        tbl[4] = '{l: 1, r: 1, u: 0, d: 0, ex: 304, ey: 400, ef: 1, em: 0};
        tbl[5] = '{l: 0, r: 0, u: 0, d: 1, ex: 304, ey: 402, ef: 1, em: 1};
        tbl[6] = '{l: 1, r: 0, u: 1, d: 0, ex: 302, ey: 400, ef: 1, em: 1};
        tbl[7] = '{l: 0, r: 1, u: 0, d: 1, ex: 304, ey: 402, ef: 0, em: 1};

        model_reset();
        do_reset();

        // Idle frames keep the start position; second instance steps 1 -> 0.
        repeat (3) frame(0, 0, 0, 0);
        check("idle_x", student_x, 304);
        frame(1, 0, 0, 0);
        check("partial_x", d1_x, 0);
        check("partial_moving", d1_moving, 1);
        check("partial_facing", d1_facing, 1);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            frame(tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d);
            check("tbl_x", student_x, tbl[i].ex);
            check("tbl_y", student_y, tbl[i].ey);
            check("tbl_facing", facing, tbl[i].ef);
            check("tbl_moving", moving, tbl[i].em);
        end

        // Left edge: walk to x=0, then keep pushing.
        guard = 0;
        while (mx > 0 && guard < 400) begin
            frame(1, 0, 0, 0);
            guard++;
        end
        repeat (5) begin
            frame(1, 0, 0, 0);
            check("ledge_x", student_x, 0);
            check("ledge_moving", moving, 0);
        end

        // Bottom edge saturation and cancelled vertical buttons.
        repeat (60) begin
            frame(0, 0, 0, 1);
            check("bottom_bound", (student_y <= 10'(Y_MAX)) ? 1 : 0, 1);
        end
        check("bottom_y", student_y, Y_MAX);
        frame(0, 0, 1, 1);
        check("updown_y", student_y, Y_MAX);
        check("updown_moving", moving, 0);

        // Walk animation over 32 moving frames.
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            frame(0, 1, 0, 0);
            check("anim_seq", anim_frame, (k / 8) % 4);
        end
        frame(0, 0, 0, 0);
        check("anim_release", anim_frame, 0);

        // Tick held into CALC must not start a second update.
        @(negedge clk);
        {btn_left, btn_right, btn_up, btn_down} = 4'b0100;
        frame_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (update_done) pulses++;
        end
        check("calc_tick_pulses", pulses, 1);
        model_step(0, 1, 0, 0);
        check("calc_tick_x", student_x, mx);

        // enable low: clears animation state, ignores ticks.
        repeat (9) frame(0, 1, 0, 0);
        check("pre_dis_anim", anim_frame, manim);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        check("dis_moving", moving, 0);
        check("dis_anim", anim_frame, 0);
        hold_x = mx;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            repeat (4) begin
                @(posedge clk); #1;
                if (update_done) pulses++;
            end
        end
        check("dis_pulses", pulses, 0);
        check("dis_x", student_x, hold_x);
        @(negedge clk);
        enable = 1'b1;
        mmoving = 0; manim = 0; mmoves = 0;
        frame(0, 1, 0, 0);

        // Reset asserted while the update sits in COMMIT.
        @(negedge clk);
        {btn_left, btn_right, btn_up, btn_down} = 4'b0100;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_x", student_x, 304);
        check("arst_y", student_y, 400);
        check("arst_flags", {facing, moving, anim_frame, update_done}, 0);
        @(posedge clk); #1;
        check("arst_done", update_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized frames with random idle gaps.
        for (int n = 0; n < 200; n++) begin
            logic [3:0] b;
            b = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            frame(b[3], b[2], b[1], b[0]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
